id_hazard_scoreboard: RTL and testbench
=======================================

ID_HAZARD_SCOREBOARD -- requirements
Module: id_hazard_scoreboard

Interface
REQ-001 SHALL have parameters: XLEN, default 32, data width; NRD, default 3, read ports (rs1/rs2/rs3); NFWD, default 2, forwarding sources (0 = EX, 1 = MEM); MAX_LAT, default 40, longest result latency in cycles.
REQ-002 SHALL use register index width 6 (bit5 = 1 selects FP file f0-f31, bit5 = 0 selects x0-x31) and LATW = clog2(MAX_LAT+1).
REQ-003 SHALL have ports:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  issue_valid_i  in  1  decoded instruction present
  issue_wr_i  in  1  instruction writes rd
  issue_rd_i  in  6  destination index
  issue_lat_i  in  LATW  cycles to result (0 = single-cycle ALU, forwarded)
  rs_used_i  in  NRD  per-port operand used
  rs_addr_i  in  NRD*6  per-port source index
  rf_data_i  in  NRD*XLEN  register file read data
  fwd_valid_i  in  NFWD  source carries a forwardable result
  fwd_addr_i  in  NFWD*6  source destination index
  fwd_data_i  in  NFWD*XLEN  source data
  wb_valid_i  in  1  writeback this cycle
  wb_addr_i  in  6  writeback index
  wb_data_i  in  XLEN  writeback data
  flush_i  in  1  squash the current issue
  ext_stall_i  in  1  downstream stall
  stall_o  out  1  hold fetch/decode
  issue_accept_o  out  1  instruction leaves decode this cycle
  rs_data_o  out  NRD*XLEN  resolved operands
  pending_o  out  64  scoreboard bits
  timeout_o  out  1  sticky watchdog error

Function
REQ-004 SHALL keep, per index 1..63 and 32 (f0), a pending bit and a LATW-bit down-counter; x0 (index 0) SHALL never be pending.
REQ-005 issue_accept_o SHALL = issue_valid_i & ~stall_o & ~flush_i.
REQ-006 On accept with issue_wr_i=1, issue_lat_i>0, rd≠x0: pending[rd] SHALL be set and counter loaded with issue_lat_i+2 on the next edge.
REQ-007 pending[i] SHALL clear on the edge where wb_valid_i & wb_addr_i==i, unless REQ-006 sets the same index that cycle (set wins).
REQ-008 Counter of a pending entry SHALL decrement once per cycle; on reaching 0 without writeback, pending SHALL clear and timeout_o SHALL set and hold until reset.
REQ-009 Operand resolution per port p, priority order: index 0 -> 0; fwd source 0..NFWD-1 with fwd_valid & fwd_addr match (lowest source number wins); wb match; else rf_data_i.
REQ-010 stall_o SHALL = ext_stall_i | RAW | WAW, where RAW = any used port with pending[addr] and no fwd/wb match that cycle; WAW = issue_valid_i & issue_wr_i & pending[issue_rd_i].
REQ-011 stall_o SHALL be combinational (zero latency); rs_data_o SHALL be combinational (no extra pipeline stage).
REQ-012 flush_i SHALL block the current issue only; entries already pending SHALL remain.
REQ-013 Counter arithmetic SHALL be unsigned, no wrap below 0; issue_lat_i > MAX_LAT SHALL saturate at MAX_LAT+2.

Reset
REQ-014 On rst_n low, all pending bits, counters and timeout_o SHALL clear asynchronously; combinational outputs SHALL follow from cleared state.
REQ-015 Reset mid-operation SHALL discard in-flight tracking; first accept after release SHALL behave as from empty.

Structure
REQ-016 Index width, FP-select bit, and default XLEN/NRD/NFWD/MAX_LAT SHALL live in the shared core defines package.
REQ-017 Operand resolution SHALL be one sub-module, operand_fwd_mux, instantiated NRD times.

Verification
REQ-018 Issue DIV x5, lat 34; next instruction uses x5 -> stall_o=1 until cycle wb_valid/addr 5 asserted, operand = wb_data that cycle, pending_o[5]=0 after edge.
REQ-019 EX fwd_valid[0] addr 7 data 0xA, MEM fwd addr 7 data 0xB, rs1=x7 -> rs_data_o port0 = 0xA, stall_o=0.
REQ-020 FMADD rs1=f1, rs2=f2, rs3=f3 with f3 (index 35) pending -> stall_o=1; x3 (index 3) not pending -> no stall for integer use of x3.
REQ-021 Issue lat 4 to x9, no writeback -> after 6 cycles pending_o[9]=0, timeout_o=1 until rst_n pulse.
REQ-022 Write to x0 lat 10 -> pending_o all 0; rs1=x0 with fwd addr 0 data 0xFF -> operand 0.
REQ-023 wb to x12 and new accept to x12 lat 5 same cycle -> pending_o[12]=1; flush_i with issue -> issue_accept_o=0, no pending change.

Source files
------------

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared core defines: register index layout and default widths for the
// decode-stage hazard scoreboard.
package id_hazard_scoreboard_pkg;

  localparam int REG_IDX_W  = 6;
  localparam int FP_SEL_BIT = 5;
  localparam int NUM_REGS   = 2 ** REG_IDX_W;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_NRD     = 3;
  localparam int DEF_NFWD    = 2;
  localparam int DEF_MAX_LAT = 40;

endpackage

// File: rtl/operand_fwd_mux.sv
// One read port's operand selection: x0, then forwarding sources in
// ascending order, then the writeback bus, then the register file.
module operand_fwd_mux
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NFWD = DEF_NFWD
) (
  input  logic [REG_IDX_W-1:0]      addr,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [NFWD-1:0]           fwd_valid,
  input  logic [NFWD*REG_IDX_W-1:0] fwd_addr,
  input  logic [NFWD*XLEN-1:0]      fwd_data,
  input  logic                      wb_valid,
  input  logic [REG_IDX_W-1:0]      wb_addr,
  input  logic [XLEN-1:0]           wb_data,
  output logic [XLEN-1:0]           data,
  output logic                      bypass_hit
);

  logic            is_zero;
  logic            wb_hit;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_sel;

  assign is_zero = ~addr[FP_SEL_BIT] & (addr[FP_SEL_BIT-1:0] == '0);
  assign wb_hit  = wb_valid & (wb_addr == addr);

  // Walk from the highest source down so the lowest-numbered match wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_sel = '0;
    for (int s = NFWD - 1; s >= 0; s--) begin
      if (fwd_valid[s] && (fwd_addr[s*REG_IDX_W +: REG_IDX_W] == addr)) begin
        fwd_hit = 1'b1;
        fwd_sel = fwd_data[s*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    data = rf_data;
    if (is_zero)      data = '0;
    else if (fwd_hit) data = fwd_sel;
    else if (wb_hit)  data = wb_data;
  end

  assign bypass_hit = fwd_hit | wb_hit;

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight long-latency writes,
// raises RAW/WAW stalls, resolves operands and flags lost writebacks.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int  XLEN    = DEF_XLEN,
  parameter int  NRD     = DEF_NRD,
  parameter int  NFWD    = DEF_NFWD,
  parameter int  MAX_LAT = DEF_MAX_LAT,
  localparam int LATW    = $clog2(MAX_LAT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid_i,
  input  logic                      issue_wr_i,
  input  logic [REG_IDX_W-1:0]      issue_rd_i,
  input  logic [LATW-1:0]           issue_lat_i,
  input  logic [NRD-1:0]            rs_used_i,
  input  logic [NRD*REG_IDX_W-1:0]  rs_addr_i,
  input  logic [NRD*XLEN-1:0]       rf_data_i,
  input  logic [NFWD-1:0]           fwd_valid_i,
  input  logic [NFWD*REG_IDX_W-1:0] fwd_addr_i,
  input  logic [NFWD*XLEN-1:0]      fwd_data_i,
  input  logic                      wb_valid_i,
  input  logic [REG_IDX_W-1:0]      wb_addr_i,
  input  logic [XLEN-1:0]           wb_data_i,
  input  logic                      flush_i,
  input  logic                      ext_stall_i,
  output logic                      stall_o,
  output logic                      issue_accept_o,
  output logic [NRD*XLEN-1:0]       rs_data_o,
  output logic [NUM_REGS-1:0]       pending_o,
  output logic                      timeout_o
);

  // Counter is sized for the saturated load value MAX_LAT+2.
  localparam int              CNTW      = $clog2(MAX_LAT + 3);
  localparam logic [CNTW-1:0] MAX_LAT_C = CNTW'(MAX_LAT);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_TWO   = CNTW'(2);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNTW-1:0]     cnt_q [NUM_REGS];
  logic [CNTW-1:0]     cnt_d [NUM_REGS];
  logic                timeout_q;
  logic                expire_any;
  logic [NRD-1:0]      bypass_hit;
  logic [NRD-1:0]      raw_hit;
  logic                waw;
  logic                rd_is_zero;
  logic                set_en;
  logic [CNTW-1:0]     lat_ext;
  logic [CNTW-1:0]     load_val;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    operand_fwd_mux #(
      .XLEN (XLEN),
      .NFWD (NFWD)
    ) u_mux (
      .addr       (rs_addr_i[p*REG_IDX_W +: REG_IDX_W]),
      .rf_data    (rf_data_i[p*XLEN +: XLEN]),
      .fwd_valid  (fwd_valid_i),
      .fwd_addr   (fwd_addr_i),
      .fwd_data   (fwd_data_i),
      .wb_valid   (wb_valid_i),
      .wb_addr    (wb_addr_i),
      .wb_data    (wb_data_i),
      .data       (rs_data_o[p*XLEN +: XLEN]),
      .bypass_hit (bypass_hit[p])
    );

    assign raw_hit[p] = rs_used_i[p]
                      & pend_q[rs_addr_i[p*REG_IDX_W +: REG_IDX_W]]
                      & ~bypass_hit[p];
  end

  assign waw            = issue_valid_i & issue_wr_i & pend_q[issue_rd_i];
  assign stall_o        = ext_stall_i | (|raw_hit) | waw;
  assign issue_accept_o = issue_valid_i & ~stall_o & ~flush_i;

  assign rd_is_zero = ~issue_rd_i[FP_SEL_BIT] & (issue_rd_i[FP_SEL_BIT-1:0] == '0);
  assign set_en     = issue_accept_o & issue_wr_i & (issue_lat_i != '0) & ~rd_is_zero;
  assign lat_ext    = CNTW'(issue_lat_i);
  assign load_val   = ((lat_ext > MAX_LAT_C) ? MAX_LAT_C : lat_ext) + CNT_TWO;

  // A new issue beats a same-cycle writeback; a writeback beats expiry.
  always_comb begin
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    expire_any = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (set_en && (issue_rd_i == REG_IDX_W'(i))) begin
        pend_d[i] = 1'b1;
        cnt_d[i]  = load_val;
      end else if (pend_q[i]) begin
        if (wb_valid_i && (wb_addr_i == REG_IDX_W'(i))) begin
          pend_d[i] = 1'b0;
          cnt_d[i]  = '0;
        end else if (cnt_q[i] <= CNT_ONE) begin
          pend_d[i]  = 1'b0;
          cnt_d[i]   = '0;
          expire_any = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end
    end
    pend_d[0] = 1'b0;
    cnt_d[0]  = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      cnt_q     <= '{default: '0};
      timeout_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | expire_any;
    end
  end

  assign pending_o = pend_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: directed hazard scenarios plus random
// traffic, all checked against a lifetime-based reference model.
module tb_id_hazard_scoreboard;

  localparam int XLEN    = 32;
  localparam int NRD     = 3;
  localparam int NFWD    = 2;
  localparam int MAX_LAT = 40;
  localparam int LATW    = $clog2(MAX_LAT + 1);
  localparam int EXP_W   = 3 + 64 + NRD * XLEN;

  logic                 clk;
  logic                 rst_n;
  logic                 issue_valid_i;
  logic                 issue_wr_i;
  logic [5:0]           issue_rd_i;
  logic [LATW-1:0]      issue_lat_i;
  logic [NRD-1:0]       rs_used_i;
  logic [NRD*6-1:0]     rs_addr_i;
  logic [NRD*XLEN-1:0]  rf_data_i;
  logic [NFWD-1:0]      fwd_valid_i;
  logic [NFWD*6-1:0]    fwd_addr_i;
  logic [NFWD*XLEN-1:0] fwd_data_i;
  logic                 wb_valid_i;
  logic [5:0]           wb_addr_i;
  logic [XLEN-1:0]      wb_data_i;
  logic                 flush_i;
  logic                 ext_stall_i;
  logic                 stall_o;
  logic                 issue_accept_o;
  logic [NRD*XLEN-1:0]  rs_data_o;
  logic [63:0]          pending_o;
  logic                 timeout_o;

  int checks   = 0;
  int failures = 0;

  logic [EXP_W-1:0] exp_q[$];

  // Reference model: a register is busy until its absolute deadline edge.
  bit [63:0] m_pend;
  int        m_deadline [64];
  bit        m_timeout;
  int        m_edge;

  logic [5:0] pool [11] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd7, 6'd9,
                            6'd12, 6'd32, 6'd33, 6'd35};

  id_hazard_scoreboard #(
    .XLEN    (XLEN),
    .NRD     (NRD),
    .NFWD    (NFWD),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid_i  (issue_valid_i),
    .issue_wr_i     (issue_wr_i),
    .issue_rd_i     (issue_rd_i),
    .issue_lat_i    (issue_lat_i),
    .rs_used_i      (rs_used_i),
    .rs_addr_i      (rs_addr_i),
    .rf_data_i      (rf_data_i),
    .fwd_valid_i    (fwd_valid_i),
    .fwd_addr_i     (fwd_addr_i),
    .fwd_data_i     (fwd_data_i),
    .wb_valid_i     (wb_valid_i),
    .wb_addr_i      (wb_addr_i),
    .wb_data_i      (wb_data_i),
    .flush_i        (flush_i),
    .ext_stall_i    (ext_stall_i),
    .stall_o        (stall_o),
    .issue_accept_o (issue_accept_o),
    .rs_data_o      (rs_data_o),
    .pending_o      (pending_o),
    .timeout_o      (timeout_o)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=time_expired required=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model
  function automatic logic [XLEN-1:0] m_operand(input int p, output bit hit);
    logic [5:0] a;
    a   = rs_addr_i[p*6 +: 6];
    hit = 1'b0;
    if (a == 6'd0) return '0;
    for (int s = 0; s < NFWD; s++) begin
      if (fwd_valid_i[s] && fwd_addr_i[s*6 +: 6] == a) begin
        hit = 1'b1;
        return fwd_data_i[s*XLEN +: XLEN];
      end
    end
    if (wb_valid_i && wb_addr_i == a) begin
      hit = 1'b1;
      return wb_data_i;
    end
    return rf_data_i[p*XLEN +: XLEN];
  endfunction

  function automatic bit m_stall();
    bit              hit;
    bit              raw;
    logic [XLEN-1:0] d;
    raw = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      d = m_operand(p, hit);
      if (rs_used_i[p] && m_pend[rs_addr_i[p*6 +: 6]] && !hit) raw = 1'b1;
    end
    return ext_stall_i || raw || (issue_valid_i && issue_wr_i && m_pend[issue_rd_i]);
  endfunction

  task automatic model_edge(input bit acc);
    int lat;
    bit set;
    m_edge++;
    lat = (int'(issue_lat_i) > MAX_LAT) ? MAX_LAT : int'(issue_lat_i);
    set = acc && issue_wr_i && (lat != 0) && (issue_rd_i != 6'd0);
    for (int i = 1; i < 64; i++) begin
      if (set && int'(issue_rd_i) == i) begin
        m_pend[i]     = 1'b1;
        m_deadline[i] = m_edge + lat + 2;
      end else if (m_pend[i] && wb_valid_i && int'(wb_addr_i) == i) begin
        m_pend[i] = 1'b0;
      end else if (m_pend[i] && m_edge >= m_deadline[i]) begin
        m_pend[i] = 1'b0;
        m_timeout = 1'b1;
      end
    end
  endtask

  // Driver tasks: inputs change at posedge+1, model advances on posedge.
  task automatic step();
    logic [NRD*XLEN-1:0] ops;
    bit                  hit;
    bit                  st;
    bit                  acc;
    if (!rst_n) begin
      m_pend    = '0;
      m_timeout = 1'b0;
    end
    for (int p = 0; p < NRD; p++) ops[p*XLEN +: XLEN] = m_operand(p, hit);
    st  = m_stall();
    acc = issue_valid_i && !st && !flush_i;
    exp_q.push_back({st, acc, m_timeout, m_pend, ops});
    @(posedge clk);
    if (rst_n) model_edge(acc);
    #1;
  endtask

  task automatic idle();
    rst_n         = 1'b1;
    issue_valid_i = 1'b0;
    issue_wr_i    = 1'b0;
    issue_rd_i    = '0;
    issue_lat_i   = '0;
    rs_used_i     = '0;
    rs_addr_i     = '0;
    for (int p = 0; p < NRD; p++) rf_data_i[p*XLEN +: XLEN] = $urandom();
    fwd_valid_i   = '0;
    fwd_addr_i    = '0;
    fwd_data_i    = '0;
    wb_valid_i    = 1'b0;
    wb_addr_i     = '0;
    wb_data_i     = '0;
    flush_i       = 1'b0;
    ext_stall_i   = 1'b0;
  endtask

  task automatic set_issue(input logic [5:0] rd, input int lat);
    issue_valid_i = 1'b1;
    issue_wr_i    = 1'b1;
    issue_rd_i    = rd;
    issue_lat_i   = LATW'(lat);
  endtask

  task automatic use_rs(input int p, input logic [5:0] a);
    rs_used_i[p]      = 1'b1;
    rs_addr_i[p*6 +: 6] = a;
  endtask

  task automatic set_fwd(input int s, input logic [5:0] a, input logic [XLEN-1:0] d);
    fwd_valid_i[s]             = 1'b1;
    fwd_addr_i[s*6 +: 6]       = a;
    fwd_data_i[s*XLEN +: XLEN] = d;
  endtask

  task automatic set_wb(input logic [5:0] a, input logic [XLEN-1:0] d);
    wb_valid_i = 1'b1;
    wb_addr_i  = a;
    wb_data_i  = d;
  endtask

  task automatic peek();
    #1;
  endtask

  function automatic logic [5:0] pick();
    return pool[$urandom_range(10, 0)];
  endfunction

  // Scoreboard monitor
  initial begin : monitor
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stall_o", 128'(stall_o), 128'(e[EXP_W-1]));
        check("issue_accept_o", 128'(issue_accept_o), 128'(e[EXP_W-2]));
        check("timeout_o", 128'(timeout_o), 128'(e[EXP_W-3]));
        check("pending_o", 128'(pending_o), 128'(e[NRD*XLEN +: 64]));
        for (int p = 0; p < NRD; p++)
          check($sformatf("rs_data_o[%0d]", p), 128'(rs_data_o[p*XLEN +: XLEN]),
                128'(e[p*XLEN +: XLEN]));
      end
    end
  end

  initial begin : driver
    int r;
    m_pend    = '0;
    m_timeout = 1'b0;
    m_edge    = 0;
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    peek();
    check("reset_pending", 128'(pending_o), 128'(0));
    check("reset_timeout", 128'(timeout_o), 128'(0));
    step();
    step();
    idle();
    step();

    // Long-latency producer, dependent consumer released by writeback.
    idle(); set_issue(6'd5, 34); peek();
    check("div_accept", 128'(issue_accept_o), 128'(1));
    step();
    for (int i = 0; i < 8; i++) begin
      idle(); use_rs(0, 6'd5); peek();
      check("raw_stall_x5", 128'(stall_o), 128'(1));
      step();
    end
    idle(); use_rs(0, 6'd5); set_wb(6'd5, 32'hDEAD_BEEF); peek();
    check("raw_wb_release", 128'(stall_o), 128'(0));
    check("wb_operand", 128'(rs_data_o[XLEN-1:0]), 128'(32'hDEAD_BEEF));
    step();
    idle(); peek();
    check("x5_cleared", 128'(pending_o[5]), 128'(0));
    step();

    // EX source beats MEM source for the same index.
    idle(); set_issue(6'd7, 3); step();
    idle(); use_rs(0, 6'd7); set_fwd(0, 6'd7, 32'hA); set_fwd(1, 6'd7, 32'hB); peek();
    check("fwd_no_stall", 128'(stall_o), 128'(0));
    check("fwd_ex_priority", 128'(rs_data_o[XLEN-1:0]), 128'(32'hA));
    step();
    idle(); set_wb(6'd7, 32'h0); step();

    // FP and integer files are distinct.
    idle(); set_issue(6'd35, 6); step();
    idle(); use_rs(0, 6'd33); use_rs(1, 6'd34); use_rs(2, 6'd35); peek();
    check("fp_f3_stall", 128'(stall_o), 128'(1));
    step();
    idle(); use_rs(0, 6'd3); peek();
    check("int_x3_no_stall", 128'(stall_o), 128'(0));
    step();
    idle(); set_wb(6'd35, 32'h1234); step();

    // x0 is never tracked and always reads zero.
    idle(); set_issue(6'd0, 10); step();
    idle(); use_rs(0, 6'd0); set_fwd(0, 6'd0, 32'hFF); peek();
    check("x0_not_pending", 128'(pending_o), 128'(0));
    check("x0_operand_zero", 128'(rs_data_o[XLEN-1:0]), 128'(0));
    step();

    // Same-cycle set and writeback; flush blocks only the current issue.
    idle(); set_issue(6'd12, 5); set_wb(6'd12, 32'h5); step();
    idle(); peek();
    check("set_wins_x12", 128'(pending_o[12]), 128'(1));
    set_issue(6'd13, 5); flush_i = 1'b1; peek();
    check("flush_blocks_accept", 128'(issue_accept_o), 128'(0));
    step();
    idle(); peek();
    check("flush_no_set_x13", 128'(pending_o[13]), 128'(0));
    check("flush_keeps_x12", 128'(pending_o[12]), 128'(1));
    set_wb(6'd12, 32'h6); step();

    // Reset mid-flight, then behave as if empty.
    idle(); set_issue(6'd5, 20); step();
    idle(); rst_n = 1'b0; peek();
    check("midreset_pending", 128'(pending_o), 128'(0));
    step();
    idle(); set_issue(6'd5, 3); peek();
    check("post_reset_accept", 128'(issue_accept_o), 128'(1));
    step();
    idle(); set_wb(6'd5, 32'h0); step();

    // Lost writeback: lat 4 expires after 6 edges and latches timeout.
    idle(); set_issue(6'd9, 4); step();
    for (int i = 0; i < 6; i++) begin
      idle(); peek();
      check("x9_still_pending", 128'(pending_o[9]), 128'(1));
      step();
    end
    idle(); peek();
    check("x9_expired", 128'(pending_o[9]), 128'(0));
    check("timeout_set", 128'(timeout_o), 128'(1));
    step();
    idle(); step();
    idle(); peek();
    check("timeout_sticky", 128'(timeout_o), 128'(1));
    rst_n = 1'b0; step();
    idle(); peek();
    check("timeout_cleared", 128'(timeout_o), 128'(0));
    step();

    // Oversized latency saturates at MAX_LAT+2 edges.
    idle(); set_issue(6'd20, 63); step();
    for (int i = 0; i < 41; i++) begin
      idle(); step();
    end
    idle(); peek();
    check("sat_still_pending", 128'(pending_o[20]), 128'(1));
    step();
    idle(); peek();
    check("sat_expired", 128'(pending_o[20]), 128'(0));
    rst_n = 1'b0; step();

    // Random traffic on a small index pool to force collisions.
    for (int n = 0; n < 2500; n++) begin
      idle();
      if ($urandom_range(99, 0) < 60) begin
        issue_valid_i = 1'b1;
        issue_wr_i    = ($urandom_range(99, 0) < 75);
        issue_rd_i    = pick();
        r = $urandom_range(99, 0);
        if (r < 20)      issue_lat_i = '0;
        else if (r < 90) issue_lat_i = LATW'($urandom_range(8, 1));
        else             issue_lat_i = LATW'($urandom_range(63, 30));
      end
      for (int p = 0; p < NRD; p++)
        if ($urandom_range(1, 0) == 1) use_rs(p, pick());
      for (int s = 0; s < NFWD; s++)
        if ($urandom_range(99, 0) < 25) set_fwd(s, pick(), $urandom());
      if ($urandom_range(99, 0) < 30) set_wb(pick(), $urandom());
      flush_i     = ($urandom_range(99, 0) < 5);
      ext_stall_i = ($urandom_range(99, 0) < 8);
      if ($urandom_range(199, 0) == 0) rst_n = 1'b0;
      step();
    end

    idle();
    step();
    @(negedge clk);
    #1;
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
